// File: rtl/mul_pipe.sv
// mul_pipe: fully pipelined WIDTH x WIDTH integer multiplier with MUL/MULH/MULHU/MULHSU
// result modes, valid/ready handshake on both sides, pass-through tag and pipeline flush.
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);
  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam logic [1:0] MODE_MUL  = 2'b00;
  localparam logic [1:0] MODE_MULH = 2'b01;

  logic [STAGES-1:0] valid_q, valid_d, adv, load;
  logic [TAG_W-1:0]  tag_q [STAGES];
  logic [TAG_W-1:0]  tag_d [STAGES];
  logic              accept, x_sgn, y_sgn;
  logic [PW-1:0]     x_ext, y_hi_ext, pp_lo, pp_hi;

  function automatic logic [WIDTH-1:0] select_half(input logic [1:0]    mode,
                                                   input logic [PW-1:0] lo,
                                                   input logic [PW-1:0] hi);
    logic [PW-1:0] prod;
    prod = lo + (hi << HALF);
    return (mode == MODE_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
  endfunction

  // y is split into an unsigned low half and a (possibly signed) high half; all
  // arithmetic is modulo 2^(2*WIDTH), so the extended operands carry the signedness.
  always_comb begin
    x_sgn    = in_x[WIDTH-1] & in_mode[0];
    y_sgn    = in_y[WIDTH-1] & (in_mode == MODE_MULH);
    x_ext    = {{WIDTH{x_sgn}}, in_x};
    y_hi_ext = {{(WIDTH+HALF){y_sgn}}, in_y[WIDTH-1:HALF]};
    pp_lo    = x_ext * {{(PW-HALF){1'b0}}, in_y[HALF-1:0]};
    pp_hi    = x_ext * y_hi_ext;
  end

  // A stage can move if any stage from it to the head is empty or the head is consumed.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_adv
    assign adv[gi] = out_ready | ~(&valid_q[STAGES-1:gi]);
  end

  assign in_ready  = ~flush & adv[0];
  assign accept    = in_valid & in_ready;
  assign out_valid = valid_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

  always_comb begin
    load     = '0;
    load[0]  = accept;
    valid_d  = valid_q;
    if (adv[0]) valid_d[0] = accept;
    tag_d[0] = load[0] ? in_tag : tag_q[0];
    for (int k = 1; k < STAGES; k++) begin
      load[k]  = adv[k] & valid_q[k-1];
      if (adv[k]) valid_d[k] = valid_q[k-1];
      tag_d[k] = load[k] ? tag_q[k-1] : tag_q[k];
    end
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) tag_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  if (STAGES == 1) begin : g_single
    logic [WIDTH-1:0] res_q, res_d;

    always_comb res_d = load[0] ? select_half(in_mode, pp_lo, pp_hi) : res_q;

    always_ff @(posedge clk) begin
      if (reset) res_q <= '0;
      else       res_q <= res_d;
    end

    assign out_result = res_q;
  end else begin : g_multi
    // Stage 0 holds the partial products; stage 1 sums them and picks the half.
    logic [PW-1:0]    pp_lo_q, pp_lo_d, pp_hi_q, pp_hi_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] res_q [1:STAGES-1];
    logic [WIDTH-1:0] res_d [1:STAGES-1];

    always_comb begin
      pp_lo_d  = load[0] ? pp_lo : pp_lo_q;
      pp_hi_d  = load[0] ? pp_hi : pp_hi_q;
      mode_d   = load[0] ? in_mode : mode_q;
      res_d[1] = load[1] ? select_half(mode_q, pp_lo_q, pp_hi_q) : res_q[1];
      for (int k = 2; k < STAGES; k++) begin
        res_d[k] = load[k] ? res_q[k-1] : res_q[k];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        pp_lo_q <= '0;
        pp_hi_q <= '0;
        mode_q  <= '0;
        for (int k = 1; k < STAGES; k++) res_q[k] <= '0;
      end else begin
        pp_lo_q <= pp_lo_d;
        pp_hi_q <= pp_hi_d;
        mode_q  <= mode_d;
        res_q   <= res_d;
      end
    end

    assign out_result = res_q[STAGES-1];
  end

endmodule
